// File: rtl/switch_pkg.sv
// Shared definitions for the switch event decoder: event codes, the
// per-switch repeat FSM encoding and the switch count.
package switch_pkg;

  localparam int N_SW = 4;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } rpt_state_e;

  // Within one switch press goes first, then repeat, then release.
  function automatic logic [1:0] pick_code(input logic p, input logic t);
    logic [1:0] code;
    if (p) begin
      code = EVT_PRESS;
    end else if (t) begin
      code = EVT_REPEAT;
    end else begin
      code = EVT_RELEASE;
    end
    return code;
  endfunction

endpackage

// File: rtl/switch_repeat_timer.sv
// Per-switch hold/auto-repeat FSM: raises a one-cycle repeat strobe after the
// hold delay and then once every repeat period until the switch is released.
module switch_repeat_timer #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic CLK,
  input  logic RST,
  input  logic iPRESS,
  input  logic iRELEASE,
  output logic oREPEAT
);
  import switch_pkg::*;

  rpt_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             hold_done_s;
  logic             rpt_done_s;

  assign hold_done_s = (cnt_r == CNT_W'(HOLD_CYCLES - 1));
  assign rpt_done_s  = (cnt_r == CNT_W'(REPEAT_CYCLES - 1));

  // The strobe lines up with the edge that moves the counter, so the pending
  // bit lands exactly HOLD_CYCLES after the press sample; a release beats it.
  assign oREPEAT = !iRELEASE &&
                   (((state_r == ST_HOLD)   && hold_done_s) ||
                    ((state_r == ST_REPEAT) && rpt_done_s));

  // State and counter update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else if (iRELEASE) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else if (iPRESS) begin
      state_r <= ST_HOLD;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
        end
        ST_HOLD: begin
          if (hold_done_s) begin
            state_r <= ST_REPEAT;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (rpt_done_s) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_event_decoder.sv
// Turns debounced switch levels into press/repeat/release events delivered
// one at a time over a valid/ready handshake, with a sticky drop flag.
module switch_event_decoder #(
  parameter int N_SW          = 4,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_SW-1:0] iSWITCH,
  output logic [N_SW-1:0] oLEVEL,
  output logic            oEVT_VALID,
  input  logic            iEVT_READY,
  output logic [1:0]      oEVT_CODE,
  output logic [1:0]      oEVT_ID,
  output logic            oOVERFLOW
);
  import switch_pkg::*;

  logic [N_SW-1:0] press_edge_s;
  logic [N_SW-1:0] release_edge_s;
  logic [N_SW-1:0] repeat_s;
  logic [N_SW-1:0] p_r, t_r, r_r;
  logic [N_SW-1:0] clr_p_s, clr_t_s, clr_r_s;
  logic [N_SW-1:0] p_after_s, r_after_s;
  logic [N_SW-1:0] press_drop_s, release_drop_s;
  logic            load_s;
  logic            win_any_s;
  logic [1:0]      win_id_s;
  logic [1:0]      win_code_s;

  assign press_edge_s   = iSWITCH & ~oLEVEL;
  assign release_edge_s = ~iSWITCH & oLEVEL;
  assign load_s         = !oEVT_VALID || iEVT_READY;

  for (genvar g = 0; g < N_SW; g++) begin : g_timer
    switch_repeat_timer #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_timer (
      .CLK     (CLK),
      .RST     (RST),
      .iPRESS  (press_edge_s[g]),
      .iRELEASE(release_edge_s[g]),
      .oREPEAT (repeat_s[g])
    );
  end

  // Fixed-priority arbiter: scanning downwards leaves the lowest index.
  always_comb begin
    win_any_s  = 1'b0;
    win_id_s   = 2'b00;
    win_code_s = EVT_PRESS;
    for (int i = N_SW - 1; i >= 0; i--) begin
      win_code_s = (p_r[i] | t_r[i] | r_r[i]) ? pick_code(p_r[i], t_r[i]) : win_code_s;
      win_id_s   = (p_r[i] | t_r[i] | r_r[i]) ? 2'(i) : win_id_s;
      win_any_s  = win_any_s | p_r[i] | t_r[i] | r_r[i];
    end
  end

  // Clear the bit being loaded; drop checks see the post-load state so a
  // same-cycle set simply re-queues instead of overflowing.
  always_comb begin
    clr_p_s = '0;
    clr_t_s = '0;
    clr_r_s = '0;
    for (int i = 0; i < N_SW; i++) begin
      clr_p_s[i] = load_s && win_any_s && (win_id_s == 2'(i)) && (win_code_s == EVT_PRESS);
      clr_t_s[i] = load_s && win_any_s && (win_id_s == 2'(i)) && (win_code_s == EVT_REPEAT);
      clr_r_s[i] = load_s && win_any_s && (win_id_s == 2'(i)) && (win_code_s == EVT_RELEASE);
    end
  end

  assign p_after_s      = p_r & ~clr_p_s;
  assign r_after_s      = r_r & ~clr_r_s;
  assign press_drop_s   = press_edge_s & (p_after_s | r_after_s);
  assign release_drop_s = release_edge_s & r_after_s;

  // Level register, pending bits, overflow flag and output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      oLEVEL     <= '0;
      p_r        <= '0;
      t_r        <= '0;
      r_r        <= '0;
      oEVT_VALID <= 1'b0;
      oEVT_CODE  <= 2'b00;
      oEVT_ID    <= 2'b00;
      oOVERFLOW  <= 1'b0;
    end else begin
      oLEVEL <= iSWITCH;
      p_r    <= p_after_s | (press_edge_s & ~press_drop_s);
      t_r    <= (t_r & ~clr_t_s) | repeat_s;
      r_r    <= r_after_s | (release_edge_s & ~release_drop_s);
      if ((|press_drop_s) || (|release_drop_s)) begin
        oOVERFLOW <= 1'b1;
      end
      if (load_s) begin
        oEVT_VALID <= win_any_s;
        if (win_any_s) begin
          oEVT_CODE <= win_code_s;
          oEVT_ID   <= win_id_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_event_decoder.sv
// Directed bench for switch_event_decoder with short hold/repeat delays.
module tb_switch_event_decoder;

  localparam logic [1:0] C_PR = 2'b00;
  localparam logic [1:0] C_RL = 2'b01;
  localparam logic [1:0] C_RP = 2'b10;

  logic       CLK;
  logic       RST;
  logic [3:0] iSWITCH;
  logic [3:0] oLEVEL;
  logic       oEVT_VALID;
  logic       iEVT_READY;
  logic [1:0] oEVT_CODE;
  logic [1:0] oEVT_ID;
  logic       oOVERFLOW;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] sw;
    logic       rdy;
    logic       v;
    logic [1:0] code;
    logic [1:0] id;
    logic       ovf;
    logic [3:0] lvl;
  } vec_t;

  vec_t vecs[15];

  switch_event_decoder #(
    .N_SW(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(25)
  ) dut (
    .CLK(CLK), .RST(RST), .iSWITCH(iSWITCH), .oLEVEL(oLEVEL),
    .oEVT_VALID(oEVT_VALID), .iEVT_READY(iEVT_READY),
    .oEVT_CODE(oEVT_CODE), .oEVT_ID(oEVT_ID), .oOVERFLOW(oOVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_evt(input string name, input logic v, input logic [1:0] code,
                         input logic [1:0] id, input logic ovf);
    chk({name, "_valid"}, 32'(oEVT_VALID), 32'(v));
    if (v) begin
      chk({name, "_code"}, 32'(oEVT_CODE), 32'(code));
      chk({name, "_id"}, 32'(oEVT_ID), 32'(id));
    end
    chk({name, "_ovf"}, 32'(oOVERFLOW), 32'(ovf));
  endtask

  initial begin
    logic       ev;
    logic [1:0] ec;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{4'b0000, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0010, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0010};
    vecs[2]  = '{4'b0010, 1'b1, 1'b1, C_PR, 2'd1, 1'b0, 4'b0010};
    vecs[3]  = '{4'b0010, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0010};
    vecs[4]  = '{4'b0000, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b1, 1'b1, C_RL, 2'd1, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0000, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0000};
    vecs[7]  = '{4'b1001, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b1001};
    vecs[8]  = '{4'b1001, 1'b1, 1'b1, C_PR, 2'd0, 1'b0, 4'b1001};
    vecs[9]  = '{4'b1001, 1'b1, 1'b1, C_PR, 2'd3, 1'b0, 4'b1001};
    vecs[10] = '{4'b1001, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b1001};
    vecs[11] = '{4'b0000, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0000};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, C_RL, 2'd0, 1'b0, 4'b0000};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, C_RL, 2'd3, 1'b0, 4'b0000};
    vecs[14] = '{4'b0000, 1'b1, 1'b0, C_PR, 2'd0, 1'b0, 4'b0000};

    RST = 1'b1; iSWITCH = 4'b0000; iEVT_READY = 1'b0;
    tick(); tick();
    chk_evt("reset", 1'b0, C_PR, 2'd0, 1'b0);
    chk("reset_code", 32'(oEVT_CODE), 32'd0);
    chk("reset_id", 32'(oEVT_ID), 32'd0);
    chk("reset_level", 32'(oLEVEL), 32'd0);
    RST = 1'b0;

    // Tap on switch 1, then simultaneous press/release of switches 0 and 3.
    for (int i = 0; i < 15; i++) begin
      iSWITCH = vecs[i].sw;
      iEVT_READY = vecs[i].rdy;
      tick();
      chk_evt($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].id, vecs[i].ovf);
      chk($sformatf("vec%0d_level", i), 32'(oLEVEL), 32'(vecs[i].lvl));
    end

    // Hold switch 0 for 20 samples with ready high.
    iEVT_READY = 1'b1;
    for (int c = 0; c < 23; c++) begin
      iSWITCH = (c < 20) ? 4'b0001 : 4'b0000;
      tick();
      case (c)
        1:         begin ev = 1'b1; ec = C_PR; end
        9, 13, 17: begin ev = 1'b1; ec = C_RP; end
        21:        begin ev = 1'b1; ec = C_RL; end
        default:   begin ev = 1'b0; ec = C_PR; end
      endcase
      chk_evt($sformatf("hold_c%0d", c), ev, ec, 2'd0, 1'b0);
    end

    // Repeats coalesce while the consumer stalls.
    iEVT_READY = 1'b0;
    for (int c = 0; c < 33; c++) begin
      iSWITCH = (c < 30) ? 4'b0001 : 4'b0000;
      iEVT_READY = (c >= 30);
      tick();
      if (c == 0)       chk_evt("coal_c0", 1'b0, C_PR, 2'd0, 1'b0);
      else if (c < 30)  chk_evt($sformatf("coal_c%0d", c), 1'b1, C_PR, 2'd0, 1'b0);
      else if (c == 30) chk_evt("coal_c30", 1'b1, C_RP, 2'd0, 1'b0);
      else if (c == 31) chk_evt("coal_c31", 1'b1, C_RL, 2'd0, 1'b0);
      else              chk_evt("coal_c32", 1'b0, C_PR, 2'd0, 1'b0);
    end

    // Backpressure: second press on switch 2 is dropped, output stays frozen.
    iEVT_READY = 1'b0;
    iSWITCH = 4'b0100; tick(); chk_evt("bp_c0", 1'b0, C_PR, 2'd0, 1'b0);
    iSWITCH = 4'b0100; tick(); chk_evt("bp_c1", 1'b1, C_PR, 2'd2, 1'b0);
    iSWITCH = 4'b0000; tick(); chk_evt("bp_c2", 1'b1, C_PR, 2'd2, 1'b0);
    iSWITCH = 4'b0100; tick(); chk_evt("bp_c3", 1'b1, C_PR, 2'd2, 1'b1);
    iSWITCH = 4'b0000; tick(); chk_evt("bp_c4", 1'b1, C_PR, 2'd2, 1'b1);
    tick();                    chk_evt("bp_c5", 1'b1, C_PR, 2'd2, 1'b1);
    iEVT_READY = 1'b1;
    tick();                    chk_evt("bp_c6", 1'b1, C_RL, 2'd2, 1'b1);
    tick();                    chk_evt("bp_c7", 1'b0, C_PR, 2'd0, 1'b1);

    // Reset mid-handshake with switch 3 still held.
    iEVT_READY = 1'b0;
    iSWITCH = 4'b1000; tick(); chk_evt("rst_c0", 1'b0, C_PR, 2'd0, 1'b1);
    tick();                    chk_evt("rst_c1", 1'b1, C_PR, 2'd3, 1'b1);
    RST = 1'b1;
    tick();
    chk_evt("rst_c2", 1'b0, C_PR, 2'd0, 1'b0);
    chk("rst_c2_code", 32'(oEVT_CODE), 32'd0);
    chk("rst_c2_id", 32'(oEVT_ID), 32'd0);
    chk("rst_c2_level", 32'(oLEVEL), 32'd0);
    RST = 1'b0;
    tick();
    chk_evt("rst_c3", 1'b0, C_PR, 2'd0, 1'b0);
    chk("rst_c3_level", 32'(oLEVEL), 32'h8);
    tick();                    chk_evt("rst_c4", 1'b1, C_PR, 2'd3, 1'b0);
    iEVT_READY = 1'b1;
    tick();                    chk_evt("rst_c5", 1'b0, C_PR, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_event_decoder.md
# switch_event_decoder

Converts the four debounced switch levels from the input-conditioning stage into a stream of discrete key events: press, release, and auto-repeat while held. Events are delivered one at a time over a valid/ready handshake to the control FSM. The block sits directly downstream of the switch debouncer and is the consumer side of its clean-level output.

## Interface
Parameters:
- N_SW, 4: number of switch lines. Fixed at 4; the ID field is 2 bits.
- HOLD_CYCLES, 25_000_000: press-to-first-repeat delay (0.5 s at 50 MHz). Must be ≥ 2.
- REPEAT_CYCLES, 5_000_000: repeat period after the first repeat (0.1 s). Must be ≥ 2.
- CNT_W, 25: hold/repeat counter width. Must satisfy 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- CLK, in, 1: the single clock; all logic is on posedge.
- RST, in, 1: reset, synchronous and active-high.
- iSWITCH, in, 4: debounced levels; 1 = pressed.
- oLEVEL, out, 4: registered copy of iSWITCH, used for edge detection.
- oEVT_VALID, out, 1: an event is presented.
- iEVT_READY, in, 1: the consumer accepts the event.
- oEVT_CODE, out, 2: 00 = press, 01 = release, 10 = repeat, 11 = never driven.
- oEVT_ID, out, 2: switch index 0..3.
- oOVERFLOW, out, 1: sticky flag; set when an event is dropped, cleared only by RST.

## Operation
- Reset: every output is 0, every pending bit is 0, every per-switch FSM is IDLE, every counter is 0.
- Edge detection: each cycle compares iSWITCH[i] against oLEVEL[i], then sets oLEVEL ← iSWITCH.
  - A 0→1 change is a press edge; a 1→0 change is a release edge.
  - A switch already high when reset is released produces a press on the first cycle after reset.
- Per-switch FSM states: IDLE, HOLD, REPEAT.
  - IDLE → HOLD on a press edge; counter cleared to 0.
  - HOLD: the counter increments each cycle. At count == HOLD_CYCLES−1, set repeat-pending, clear the counter, go to REPEAT.
  - REPEAT: at count == REPEAT_CYCLES−1, set repeat-pending and clear the counter.
  - A release edge in any state → IDLE, counter cleared.
- Pending bits: each switch has three, P (press), T (repeat), R (release).
  - A press edge while P or R is already set is dropped and sets oOVERFLOW.
  - A release edge while R is already set is dropped and sets oOVERFLOW.
  - A repeat while T is already set coalesces: it is dropped silently with no overflow.
- Arbitration:
  - Switches: lowest index wins.
  - Within a switch: P before T before R. This preserves per-switch chronological order.
- Output register:
  - It loads when oEVT_VALID == 0, or when oEVT_VALID && iEVT_READY in that cycle.
  - On load it takes the winning pending bit and clears that bit in the same cycle.
  - If nothing is pending, oEVT_VALID drops to 0.
- Handshake:
  - oEVT_CODE and oEVT_ID are stable while oEVT_VALID && !iEVT_READY.
  - oEVT_VALID never drops without a transfer.
- A pending bit being set and the same bit being cleared by a load in the same cycle: the set wins. The event is re-queued and no overflow is raised.

## Timing
- Latency: a change on iSWITCH sampled at edge k sets its pending bit at k. If the output register is free, oEVT_VALID is high after edge k+1.
- Throughput: one event per cycle under continuous iEVT_READY.
- First repeat: exactly HOLD_CYCLES cycles after the press-edge sample. Each later repeat follows REPEAT_CYCLES cycles after the previous one.
- RST asserted mid-handshake: oEVT_VALID is 0 on the next cycle, and all pending events are discarded.

## Structure
- Shared package `switch_pkg`:
  - Event-code constants EVT_PRESS, EVT_RELEASE, EVT_REPEAT.
  - The IDLE/HOLD/REPEAT state encoding.
  - N_SW.
- Sub-module `switch_repeat_timer`, instantiated N_SW times:
  - Contains one per-switch FSM and its counter.
  - Inputs: press/release edges. Output: a one-cycle repeat strobe.
- The top level holds the edge detection, pending bits, arbiter, output register and overflow flag.

## Test plan
Run with HOLD_CYCLES = 8 and REPEAT_CYCLES = 4.
- Tap: iSWITCH 0000→0010 for 3 cycles, then back to 0000, with iEVT_READY = 1 → events (press, 1) then (release, 1). oEVT_VALID first rises 2 cycles after the input change.
- Hold: iSWITCH[0] held for 20 cycles → press, then repeats at +8, +12, +16, then release. No overflow.
- Simultaneous press: iSWITCH 0000→1001 → (press, 0) then (press, 3) on consecutive cycles.
- Backpressure: iEVT_READY = 0 while switch 2 is tapped twice → first tap: P and R pending. Second press edge: dropped, oOVERFLOW = 1. oEVT_CODE and oEVT_ID stay frozen until ready rises.
- Repeat coalescing: iEVT_READY = 0 for 30 cycles while switch 0 is held → only one repeat is delivered after ready rises, and oOVERFLOW stays 0.
- Reset mid-stream: RST pulsed for 1 cycle while oEVT_VALID = 1 → all outputs are 0 on the next cycle. A still-held switch then yields a fresh press.
